chebyshev_coeff_sequencer: RTL and testbench

//  Stage directly upstream of chebyshev_computation; drives its data_in and coeff_in.

---
 rtl/chebyshev_coeff_sequencer.sv | 144 ++++++++++++++
 tb/tb_chebyshev_coeff_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chebyshev_coeff_sequencer.sv
// Coefficient register file plus a streamer that emits (sample, coefficient) pairs in Clenshaw order.
// Optional build macro CHEB_SEQ_LOOP_EN adds loop_en, which restarts directly from DONE.
module chebyshev_coeff_sequencer #(
    parameter int WL      = 2,
    parameter int CL      = 2,
    parameter int N_COEFF = 4,
    parameter int AW      = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [WL-1:0] sample_in,
    input  logic          cw_en,
    input  logic [AW-1:0] cw_addr,
    input  logic [CL-1:0] cw_data,
    input  logic          out_ready,
`ifdef CHEB_SEQ_LOOP_EN
    input  logic          loop_en,
`endif
    output logic          out_valid,
    output logic [WL-1:0] data_out,
    output logic [CL-1:0] coeff_out,
    output logic [AW-1:0] coeff_idx,
    output logic          first,
    output logic          last,
    output logic          busy,
    output logic          done
);
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_STREAM = 2'd1;
    localparam logic [1:0]    S_DONE   = 2'd2;
    localparam logic [AW-1:0] IDX_TOP  = AW'(N_COEFF - 1);

    logic [1:0]    state_q, state_d;
    logic [WL-1:0] sample_q, sample_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CL-1:0] coeff_q [N_COEFF];
    logic [CL-1:0] coeff_d [N_COEFF];
    logic          xfer;
    logic          restart;

    assign xfer = valid_q && out_ready;

`ifdef CHEB_SEQ_LOOP_EN
    assign restart = ((state_q == S_IDLE) && start) || ((state_q == S_DONE) && loop_en);
`else
    assign restart = (state_q == S_IDLE) && start;
`endif

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        first_d  = first_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        coeff_d  = coeff_q;

        // Only in-range addresses match a register, so out-of-range writes fall through.
        if ((state_q == S_IDLE) && cw_en) begin
            for (int i = 0; i < N_COEFF; i++) begin
                if (cw_addr == AW'(i)) coeff_d[i] = cw_data;
            end
        end

        if (restart) begin
            state_d  = S_STREAM;
            sample_d = sample_in;
            idx_d    = IDX_TOP;
            valid_d  = 1'b1;
            first_d  = 1'b1;
            last_d   = 1'b0;
            busy_d   = 1'b1;
        end else begin
            case (state_q)
                S_STREAM: begin
                    if (xfer) begin
                        if (idx_q == '0) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            first_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q - AW'(1);
                            first_d = 1'b0;
                            last_d  = (idx_q == AW'(1));
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                S_IDLE:  ;
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sample_q <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < N_COEFF; i++) coeff_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            coeff_q  <= coeff_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = sample_q;
    assign coeff_out = coeff_q[idx_q];
    assign coeff_idx = idx_q;
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_chebyshev_coeff_sequencer.sv
// Bench for chebyshev_coeff_sequencer: table-driven sequences checked through a transfer scoreboard.
module tb_chebyshev_coeff_sequencer;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0] d;
        logic [1:0] c;
        logic [1:0] i;
        logic       f;
        logic       l;
    } exp_t;

    typedef struct {
        logic [1:0]      s;
        logic [3:0][1:0] c;
        logic [7:0]      mask;
        int              lat;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sample_in = '0;
    logic       cw_en = 1'b0;
    logic [1:0] cw_addr = '0;
    logic [1:0] cw_data = '0;
    logic       out_ready = 1'b0;
    logic       loop_en = 1'b0;
    logic       out_valid, first, last, busy, done;
    logic [1:0] data_out, coeff_out, coeff_idx;

    logic       start3 = 1'b0;
    logic [1:0] sample3 = '0;
    logic       c3_en = 1'b0;
    logic [1:0] c3_addr = '0;
    logic [1:0] c3_data = '0;
    logic       valid3, first3, last3, busy3, done3;
    logic [1:0] data3, coeff3, idx3;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    exp_t sbq[$];
    logic [1:0] model [N];

    always #5 clock = ~clock;

    chebyshev_coeff_sequencer #(.WL(2), .CL(2), .N_COEFF(N), .AW(2)) dut (
        .clock(clock), .reset(reset), .start(start), .sample_in(sample_in),
        .cw_en(cw_en), .cw_addr(cw_addr), .cw_data(cw_data), .out_ready(out_ready),
`ifdef CHEB_SEQ_LOOP_EN
        .loop_en(loop_en),
`endif
        .out_valid(out_valid), .data_out(data_out), .coeff_out(coeff_out),
        .coeff_idx(coeff_idx), .first(first), .last(last), .busy(busy), .done(done)
    );

    chebyshev_coeff_sequencer #(.WL(2), .CL(2), .N_COEFF(3), .AW(2)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .sample_in(sample3),
        .cw_en(c3_en), .cw_addr(c3_addr), .cw_data(c3_data), .out_ready(1'b1),
`ifdef CHEB_SEQ_LOOP_EN
        .loop_en(1'b0),
`endif
        .out_valid(valid3), .data_out(data3), .coeff_out(coeff3),
        .coeff_idx(idx3), .first(first3), .last(last3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [1:0] s);
        exp_t e;
        for (int idx = N - 1; idx >= 0; idx--) begin
            e.d = s;
            e.c = model[idx];
            e.i = 2'(idx);
            e.f = (idx == N - 1);
            e.l = (idx == 0);
            sbq.push_back(e);
        end
    endtask

    // Scoreboard pops on every transfer; a stall must hold the presented pair.
    logic stall_prev = 1'b0;
    exp_t held, popped;
    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold", {out_valid, data_out, coeff_out, coeff_idx, first, last}, {1'b1, held});
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    popped = sbq.pop_front();
                    chk("xfer", {data_out, coeff_out, coeff_idx, first, last}, popped);
                end
            end
            held = {data_out, coeff_out, coeff_idx, first, last};
            stall_prev = out_valid && !out_ready;
            if (done) begin
                done_cnt++;
                chk("done_state", {sbq.size() == 0, out_valid, busy}, 3'b101);
            end
        end
    end

    task automatic wr(input int a, input logic [1:0] v);
        @(posedge clock); #1;
        cw_en = 1'b1; cw_addr = 2'(a); cw_data = v;
        if (a < N) model[a] = v;
        @(posedge clock); #1;
        cw_en = 1'b0;
    endtask

    task automatic run_seq(input logic [1:0] s, input logic [7:0] mask, input int exp_lat, input bit inject);
        bit seen;
        int lat;
        seen = 1'b0;
        lat = -1;
        @(posedge clock); #1;
        start = 1'b1; sample_in = s;
        push_seq(s);
        for (int k = 0; k < 64; k++) begin
            @(posedge clock); #1;
            start = 1'b0; cw_en = 1'b0;
            if (done) begin
                seen = 1'b1; lat = k;
                break;
            end
            out_ready = mask[k % 8];
            if (inject && k == 1) begin
                start = 1'b1; cw_en = 1'b1; cw_addr = 2'd0; cw_data = ~model[0];
            end
        end
        chk("done_seen", 32'(seen), 1);
        chk("latency", lat, exp_lat);
        out_ready = 1'b0;
        @(posedge clock); #1;
        chk("idle_after_done", {busy, out_valid, done}, 3'b000);
    endtask

    initial begin
        vec_t vt [4];
        logic [1:0] e3 [3];
        bit found;
        int dc;

        vt[0].s = 2'b10; vt[0].c = {2'b01, 2'b00, 2'b11, 2'b01}; vt[0].mask = 8'hff; vt[0].lat = 4;
        vt[1].s = 2'b01; vt[1].c = {2'b01, 2'b00, 2'b11, 2'b01}; vt[1].mask = 8'hf1; vt[1].lat = 7;
        vt[2].s = 2'b11; vt[2].c = {2'b10, 2'b11, 2'b01, 2'b10}; vt[2].mask = 8'haa; vt[2].lat = 8;
        vt[3].s = 2'b10; vt[3].c = {2'b00, 2'b01, 2'b01, 2'b00}; vt[3].mask = 8'h66; vt[3].lat = 7;
        for (int i = 0; i < N; i++) model[i] = 2'b00;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_outs", {out_valid, data_out, coeff_out, coeff_idx, first, last, busy, done}, 0);
        reset = 1'b0;

        run_seq(2'b01, 8'hff, 4, 1'b0);

        for (int v = 0; v < 4; v++) begin
            for (int a = 0; a < N; a++) wr(a, vt[v].c[a]);
            run_seq(vt[v].s, vt[v].mask, vt[v].lat, 1'b0);
        end

        // Writes and start while busy are dropped; the follow-up run still sees the old c[0].
        run_seq(2'b11, 8'hff, 4, 1'b1);
        run_seq(2'b10, 8'hff, 4, 1'b0);

        // Abort at idx 1 with a reset; the register file must come back cleared.
        @(posedge clock); #1;
        start = 1'b1; sample_in = 2'b01; out_ready = 1'b1;
        push_seq(2'b01);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (out_valid && coeff_idx == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_idx1", 32'(found), 1);
        out_ready = 1'b0; reset = 1'b1; dc = done_cnt;
        @(posedge clock); #1;
        chk("abort_outs", {out_valid, busy, done}, 3'b000);
        reset = 1'b0;
        sbq.delete();
        for (int i = 0; i < N; i++) model[i] = 2'b00;
        @(posedge clock); #1;
        chk("no_done_after_abort", done_cnt, dc);
        run_seq(2'b10, 8'hff, 4, 1'b0);

`ifdef CHEB_SEQ_LOOP_EN
        wr(0, 2'b01); wr(1, 2'b10); wr(2, 2'b11); wr(3, 2'b01);
        dc = done_cnt;
        loop_en = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; sample_in = 2'b11; out_ready = 1'b1;
        push_seq(2'b11);
        push_seq(2'b01);
        @(posedge clock); #1;
        start = 1'b0; sample_in = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("loop_done1", 32'(found), 1);
        @(posedge clock); #1;
        loop_en = 1'b0;
        chk("loop_restart", {out_valid, coeff_idx, data_out, first, done}, {1'b1, 2'd3, 2'b01, 1'b1, 1'b0});
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("loop_done2", 32'(found), 1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("loop_idle", {busy, out_valid}, 2'b00);
        chk("loop_done_count", done_cnt - dc, 2);
`endif

        // Three-coefficient instance: address 3 is out of range and must be ignored.
        e3[0] = 2'b01; e3[1] = 2'b11; e3[2] = 2'b00;
        @(posedge clock); #1; c3_en = 1'b1; c3_addr = 2'd0; c3_data = 2'b01;
        @(posedge clock); #1; c3_addr = 2'd1; c3_data = 2'b11;
        @(posedge clock); #1; c3_addr = 2'd3; c3_data = 2'b01;
        @(posedge clock); #1; c3_en = 1'b0; start3 = 1'b1; sample3 = 2'b10;
        @(posedge clock); #1; start3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("n3_pair", {valid3, data3, coeff3, idx3, first3, last3},
                {1'b1, 2'b10, e3[2 - k], 2'(2 - k), k == 0, k == 2});
            @(posedge clock); #1;
        end
        chk("n3_done", {done3, valid3, busy3}, 3'b101);

        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
